// File: rtl/chi_slice_stage.sv
// Keccak-f[1600] chi step, one 25-bit slice per beat, with slice/round tracking for iota.
// Optional CHI_SKID_EN: 2-entry skid buffer with registered in_ready (default: single output register).
module chi_slice_stage #(
  parameter int SLICES = 64,
  parameter int ROUNDS = 24,
  parameter int IDX_W  = $clog2(SLICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [24:0]       in_slice,
  output logic              in_ready,
  output logic              out_valid,
  output logic [24:0]       out_slice,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  slice_idx,
  output logic [4:0]        turn,
  output logic              round_done,
  output logic              perm_done,
  output logic              busy
);

  localparam int TOTAL = SLICES * ROUNDS;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] slice_idx_q;
  logic [4:0]       turn_q;
  logic [CNT_W-1:0] in_cnt_q;
  logic             round_done_q;
  logic             perm_done_q;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             last_slice_s;
  logic             last_out_s;

  // Lane k = 5y+x lives at bit 24-k; each lane is flipped by (~next & next-next) within its row.
  function automatic logic [24:0] chi_f(input logic [24:0] a);
    logic [24:0] r;
    r = 25'h0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[24 - (5*y + x)] = a[24 - (5*y + x)]
                          ^ (~a[24 - (5*y + (x+1)%5)] & a[24 - (5*y + (x+2)%5)]);
      end
    end
    return r;
  endfunction

  assign in_fire_s    = in_valid & in_ready;
  assign out_fire_s   = out_valid & out_ready;
  assign last_slice_s = (slice_idx_q == IDX_W'(SLICES - 1));
  assign last_out_s   = last_slice_s && (turn_q == 5'(ROUNDS - 1));

  assign slice_idx  = slice_idx_q;
  assign turn       = turn_q;
  assign round_done = round_done_q;
  assign perm_done  = perm_done_q;
  assign busy       = (state_q != ST_IDLE);

  // Control FSM: counters move only on downstream transfer; in_cnt_q caps intake at one permutation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      slice_idx_q  <= '0;
      turn_q       <= 5'd0;
      in_cnt_q     <= '0;
      round_done_q <= 1'b0;
      perm_done_q  <= 1'b0;
    end else begin
      round_done_q <= 1'b0;
      perm_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            slice_idx_q <= '0;
            turn_q      <= 5'd0;
            in_cnt_q    <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (in_fire_s) begin
            in_cnt_q <= in_cnt_q + CNT_W'(1);
          end else begin
            in_cnt_q <= in_cnt_q;
          end
          if (out_fire_s) begin
            if (last_slice_s) begin
              slice_idx_q  <= '0;
              round_done_q <= 1'b1;
              if (last_out_s) begin
                turn_q      <= 5'd0;
                perm_done_q <= 1'b1;
                state_q     <= ST_DONE;
              end else begin
                turn_q <= turn_q + 5'd1;
              end
            end else begin
              slice_idx_q <= slice_idx_q + IDX_W'(1);
            end
          end else begin
            slice_idx_q <= slice_idx_q;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CHI_SKID_EN
  logic [24:0]      mem_q [2];
  logic             rd_q;
  logic             wr_q;
  logic [1:0]       cnt_q;
  logic             in_ready_q;
  logic [1:0]       cnt_d;
  logic             run_d;
  logic [CNT_W-1:0] in_cnt_d;
  logic             in_ready_d;

  assign out_valid = (cnt_q != 2'd0);
  assign out_slice = mem_q[rd_q];
  assign in_ready  = in_ready_q;

  // Next-cycle view of occupancy, FSM and intake so in_ready can be registered.
  always_comb begin
    cnt_d = cnt_q;
    if (in_fire_s && !out_fire_s) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!in_fire_s && out_fire_s) begin
      cnt_d = cnt_q - 2'd1;
    end else begin
      cnt_d = cnt_q;
    end
    run_d      = ((state_q == ST_IDLE) && start) ||
                 ((state_q == ST_RUN) && !(out_fire_s && last_out_s));
    in_cnt_d   = (state_q == ST_IDLE) ? '0 : (in_cnt_q + CNT_W'(in_fire_s));
    in_ready_d = run_d && (cnt_d != 2'd2) && (in_cnt_d < CNT_W'(TOTAL));
  end

  // Two-entry skid storage; the head entry drives out_slice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= 25'h0;
      end
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      if (in_fire_s) begin
        mem_q[wr_q] <= chi_f(in_slice);
        wr_q        <= ~wr_q;
      end else begin
        wr_q <= wr_q;
      end
      if (out_fire_s) begin
        rd_q <= ~rd_q;
      end else begin
        rd_q <= rd_q;
      end
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  logic        out_valid_q;
  logic [24:0] out_slice_q;

  assign out_valid = out_valid_q;
  assign out_slice = out_slice_q;
  assign in_ready  = (state_q == ST_RUN) && (in_cnt_q < CNT_W'(TOTAL)) &&
                     (!out_valid_q || out_ready);

  // Single output register; refilled in the same cycle it drains, held while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_slice_q <= 25'h0;
    end else if (in_fire_s) begin
      out_valid_q <= 1'b1;
      out_slice_q <= chi_f(in_slice);
    end else if (out_fire_s) begin
      out_valid_q <= 1'b0;
      out_slice_q <= out_slice_q;
    end else begin
      out_valid_q <= out_valid_q;
      out_slice_q <= out_slice_q;
    end
  end
`endif

endmodule

// File: tb/tb_chi_slice_stage.sv
// Directed bench for chi_slice_stage: hand vectors, stall, mid-run reset, full permutation.
module tb_chi_slice_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [24:0] in_slice;
  logic        in_ready;
  logic        out_valid;
  logic [24:0] out_slice;
  logic        out_ready;
  logic [5:0]  slice_idx;
  logic [4:0]  turn;
  logic        round_done;
  logic        perm_done;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int out_cnt, rd_cnt, pd_cnt, last_idx, last_turn;
  logic [24:0] src_q[$];
  logic [24:0] exp_q[$];

  chi_slice_stage dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_slice(in_slice), .in_ready(in_ready),
    .out_valid(out_valid), .out_slice(out_slice), .out_ready(out_ready),
    .slice_idx(slice_idx), .turn(turn),
    .round_done(round_done), .perm_done(perm_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [24:0] chi_ref(input logic [24:0] s);
    logic a [5][5];
    logic [24:0] r;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) a[x][y] = s[24 - (5*y + x)];
    r = 25'h0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[24 - (5*y + x)] = a[x][y] ^ (!a[(x+1)%5][y] && a[(x+2)%5][y]);
    return r;
  endfunction

  function automatic logic [24:0] gen(input int n);
    logic [31:0] t;
    t = n * 32'h9E3779B1;
    return t[24:0] ^ t[31:7];
  endfunction

  task automatic drive(input int c, input int stall_at);
    in_valid  = (src_q.size() > 0);
    in_slice  = (src_q.size() > 0) ? src_q[0] : 25'h0;
    out_ready = !(c >= stall_at && c < stall_at + 5);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Streams src_q through the DUT until n_out outputs transferred or budget expires.
  task automatic run(input int n_out, input int stall_at, input int budget);
    int c = 0;
    logic prev_stall = 1'b0;
    logic [24:0] prev_slice = 25'h0;
    logic [5:0] prev_idx = 6'd0;
    drive(c, stall_at);
    while (out_cnt < n_out && c < budget) begin
      @(negedge clk);
      if (round_done) rd_cnt++;
      if (perm_done) pd_cnt++;
      if (prev_stall) begin
        chk("hold_slice", out_slice, prev_slice);
        chk("hold_idx", slice_idx, prev_idx);
      end
      prev_stall = out_valid && !out_ready;
      prev_slice = out_slice;
      prev_idx   = slice_idx;
      if (out_valid && out_ready) begin
        chk("slice", out_slice, exp_q.pop_front());
        chk("idx", slice_idx, out_cnt % 64);
        chk("turn", turn, (out_cnt / 64) % 24);
        last_idx  = slice_idx;
        last_turn = turn;
        out_cnt++;
      end
      if (in_valid && in_ready) void'(src_q.pop_front());
      @(posedge clk); #1;
      c++;
      drive(c, stall_at);
    end
    if (out_cnt < n_out) chk("timeout", out_cnt, n_out);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_slice = 25'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0); chk("rst_slice", out_slice, 0);
    chk("rst_idx", slice_idx, 0);   chk("rst_turn", turn, 0);
    chk("rst_rd", round_done, 0);   chk("rst_pd", perm_done, 0);
    chk("rst_busy", busy, 0);       chk("rst_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Hand vectors, then generated stream with a 5-cycle stall, reset at turn 7 slice 30.
    src_q.push_back(25'h0000000); exp_q.push_back(25'h0000000);
    src_q.push_back(25'h0400000); exp_q.push_back(25'h1400000);
    src_q.push_back(25'h1FFFFFF); exp_q.push_back(25'h1FFFFFF);
    for (int i = 0; i < 600; i++) begin
      src_q.push_back(gen(i));
      exp_q.push_back(chi_ref(gen(i)));
    end
    out_cnt = 0; rd_cnt = 0; pd_cnt = 0;
    pulse_start();
    chk("busy_run", busy, 1);
    run(478, 100, 1000);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_idx", slice_idx, 30);
    chk("pre_rst_turn", turn, 7);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0); chk("mid_rst_slice", out_slice, 0);
    chk("mid_rst_idx", slice_idx, 0);   chk("mid_rst_turn", turn, 0);
    chk("mid_rst_busy", busy, 0);       chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_rd", round_done, 0);   chk("mid_rst_pd", perm_done, 0);
    @(posedge clk); #1 rst = 1'b1;
    in_valid = 1'b0;
    src_q.delete(); exp_q.delete();

    // Full permutation with four surplus slices that must never be accepted.
    for (int i = 0; i < 1540; i++) begin
      src_q.push_back(gen(i + 1000));
      exp_q.push_back(chi_ref(gen(i + 1000)));
    end
    out_cnt = 0; rd_cnt = 0; pd_cnt = 0;
    pulse_start();
    run(1536, -100, 2000);
    chk("last_idx", last_idx, 63);
    chk("last_turn", last_turn, 23);
    @(negedge clk);
    if (round_done) rd_cnt++;
    if (perm_done) pd_cnt++;
    chk("perm_pulse", perm_done, 1);
    chk("busy_done", busy, 1);
    chk("ready_done", in_ready, 0);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("ready_idle", in_ready, 0);
    chk("valid_idle", out_valid, 0);
    chk("pd_after", perm_done, 0);
    chk("round_cnt", rd_cnt, 24);
    chk("perm_cnt", pd_cnt, 1);
    chk("surplus_held", src_q.size(), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
